// File: rtl/fifo_pkg.sv
// Shared defaults and the per-cycle operation type used by the FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    // What actually happens to the FIFO contents in one cycle, after gating by flags.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
        return fifo_op_e'({rd_acc, wr_acc});
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array: written on accepted writes only; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value unless a read is accepted.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read register update; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointer, occupancy and flag logic around fifo_mem.
//
// Handshake: a write is accepted on a clk edge when wr_en=1 and full=0; a read is
// accepted when rd_en=1 and empty=0. Non-accepted requests are dropped without
// side effects. Read data appears on data_out one cycle after acceptance.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic [ADDR_WIDTH:0]   cnt_d, cnt_q;
    logic                  wr_acc;
    logic                  rd_acc;
    fifo_op_e              op;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == DEPTH_CNT);
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;
    assign op     = decode_op(wr_acc, rd_acc);

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case (op)
            OP_WRITE: cnt_d = cnt_q + 1'b1;
            OP_READ:  cnt_d = cnt_q - 1'b1;
            default:  cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt = cnt_q;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_acc),
        .wr_addr(wr_ptr_q),
        .wr_data(data_in),
        .rd_en  (rd_acc),
        .rd_addr(rd_ptr_q),
        .rd_data(data_out)
    );

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: driver updates a queue-based model and pushes expected
// read words; a monitor pops and compares them when the DUT presents read data.
module tb_fifo;

    localparam int W     = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  data_in = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  data_out;
    logic          empty;
    logic          full;
    logic [AW:0]   cnt;

    fifo #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .data_out(data_out),
        .empty   (empty),
        .full    (full),
        .cnt     (cnt)
    );

    // Clock
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: contents as a plain queue, last word read out.
    logic [W-1:0] model_q[$];
    logic [W-1:0] model_last = '0;

    // Scoreboard: expected read words in order.
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a read the DUT accepted at a posedge presents data at the next negedge.
    logic rd_pend = 1'b0;
    always @(posedge clk) rd_pend <= rd_en && !empty && !rst;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 1, 0);
            end else begin
                check("read_data", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    // Compare occupancy, flags and held data_out against the model.
    task automatic check_state(input string tag);
        check({tag, "_cnt"},   int'(cnt),      model_q.size());
        check({tag, "_empty"}, int'(empty),    int'(model_q.size() == 0));
        check({tag, "_full"},  int'(full),     int'(model_q.size() == DEPTH));
        check({tag, "_dout"},  int'(data_out), int'(model_last));
    endtask

    // Drive one cycle of requests, update the model, then check after the edge.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input string tag);
        bit m_full, m_empty;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        if (r && !m_empty) begin
            model_last = model_q.pop_front();
            exp_q.push_back(model_last);
        end
        if (w && !m_full) model_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input int cycles, input bit w, input bit r);
        rst   = 1'b1;
        wr_en = w;
        rd_en = r;
        data_in = 8'hA5;
        repeat (cycles) @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_q.delete();
        model_last = '0;
        check_state("reset");
    endtask

    initial begin
        // Reset held two cycles
        do_reset(2, 1'b0, 1'b0);

        // Push 1, then push 2 with pop -> pop yields 1, cnt stays 1
        step(1, 8'd1, 0, "push1");
        step(1, 8'd2, 1, "push2_pop");

        // Push 10..130 -> cnt 14; pop five
        for (int i = 1; i <= 13; i++) step(1, 8'(i * 10), 0, "push_tens");
        check("cnt_after_tens", int'(cnt), 14);
        for (int i = 0; i < 5; i++) step(0, 8'd0, 1, "pop_five");
        while (model_q.size() > 0) step(0, 8'd0, 1, "drain");

        // Pop on empty: nothing changes; then push 5 and pop it
        step(0, 8'd0, 1, "pop_empty");
        step(1, 8'd5, 0, "push5");
        step(0, 8'd0, 1, "pop5");

        // Simultaneous push/pop on empty: write only, no read-through
        step(1, 8'd77, 1, "wr_rd_empty");
        step(0, 8'd0, 1, "pop77");

        // Fill to DEPTH from a non-zero pointer (wraps), then overflow attempts
        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom_range(0, 255)), 0, "fill");
        check("full_at_depth", int'(full), 1);
        step(1, 8'hEE, 0, "push_full");
        step(1, 8'hDD, 1, "wr_rd_full");
        step(1, 8'hCC, 0, "refill");
        while (model_q.size() > 0) step(0, 8'd0, 1, "drain_full");

        // Reset with three words stored, requests asserted during reset
        for (int i = 0; i < 3; i++) step(1, 8'(100 + i), 0, "pre_reset");
        do_reset(1, 1'b1, 1'b1);
        step(1, 8'd42, 0, "post_reset_push");
        step(0, 8'd0, 1, "post_reset_pop");

        // Randomized traffic with varying write/read bias
        for (int phase = 0; phase < 3; phase++) begin
            for (int i = 0; i < 600; i++) begin
                bit w, r;
                w = ($urandom_range(0, 99) < (phase == 0 ? 80 : (phase == 1 ? 30 : 55)));
                r = ($urandom_range(0, 99) < (phase == 0 ? 30 : (phase == 1 ? 80 : 55)));
                step(w, 8'($urandom), r, "random");
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
